spi_master: RTL and testbench

//  Byte-oriented SPI master (initiator), drives the bus consumed by the on-board SPI slave blocks.

---
 rtl/spi_master_pkg.sv | 29 ++
 rtl/spi_sck_gen.sv | 43 ++++
 rtl/spi_master.sv | 141 ++++++++++++++
 tb/tb_spi_master.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types for the SPI master: FSM state encoding, SPI mode encodings
// and a small counter-width helper.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_NEXT,
    ST_HOLD,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = 2'b00;
  localparam spi_mode_t SPI_MODE1 = 2'b01;
  localparam spi_mode_t SPI_MODE2 = 2'b10;
  localparam spi_mode_t SPI_MODE3 = 2'b11;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: holds SCK at cpol while disabled, otherwise toggles every
// CLK_DIV cycles and flags the cycle ending in a leading or trailing edge.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic enable,
  input  logic cpol,
  output logic sck,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic [DIV_W-1:0] div_cnt;
  logic             sck_q;
  logic             half_done;

  assign half_done  = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign lead_edge  = half_done && (sck_q == cpol);
  assign trail_edge = half_done && (sck_q != cpol);
  assign sck        = sck_q;

  // NOTE: clocked state is always assigned with <= so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt <= '0;
      sck_q   <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      sck_q   <= cpol;
    end else if (half_done) begin
      div_cnt <= '0;
      sck_q   <= ~sck_q;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master with CSn burst framing. Define SPI_M_MODE_SEL_EN
// to add the i_mode[1:0] ({CPOL,CPHA}) input; otherwise fixed mode 0.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
`ifdef SPI_M_MODE_SEL_EN
  input  logic [1:0] i_mode,
`endif
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_last,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_busy,
  output logic       o_spi_m_sck,
  output logic       o_spi_m_cs_n,
  output logic       o_spi_m_mosi,
  input  logic       i_spi_m_miso
);

  localparam int WAIT_W = cnt_width((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);

  state_e            state, state_next;
  spi_mode_t         mode;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_done;
  logic              accept, lead, trail, sample, shift, done;
  logic [2:0]        bit_cnt;
  logic [7:0]        tx_sr, rx_sr, rx_next, rx_data_q;
  logic              last_q, mosi_q, cs_n_q, rx_valid_q;
  logic              miso_meta, miso_sync;

`ifdef SPI_M_MODE_SEL_EN
  spi_mode_t mode_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                            mode_q <= SPI_MODE0;
    else if (state == ST_IDLE && accept)     mode_q <= spi_mode_t'(i_mode);
  end

  // While idle the SCK level follows the requested mode so it is already
  // settled when CSn falls; the captured copy then holds for the burst.
  assign mode = (state == ST_IDLE) ? spi_mode_t'(i_mode) : mode_q;
`else
  assign mode = SPI_MODE0;
`endif

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .enable     (state == ST_SHIFT),
    .cpol       (mode.cpol),
    .sck        (o_spi_m_sck),
    .lead_edge  (lead),
    .trail_edge (trail)
  );

  assign o_tx_ready = (state == ST_IDLE) || (state == ST_NEXT);
  assign accept     = i_tx_valid && o_tx_ready;
  assign sample     = mode.cpha ? trail : lead;
  assign shift      = mode.cpha ? lead : trail;
  assign rx_next    = sample ? {rx_sr[6:0], miso_sync} : rx_sr;
  assign done       = trail && (bit_cnt == 3'd7);
  assign wait_done  = (state == ST_SETUP) ? (wait_cnt == WAIT_W'(CS_SETUP - 1))
                                          : (wait_cnt == WAIT_W'(CS_HOLD - 1));

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (accept)    state_next = ST_SETUP;
      ST_SETUP: if (wait_done) state_next = ST_SHIFT;
      ST_SHIFT: if (done)      state_next = last_q ? ST_HOLD : ST_NEXT;
      ST_NEXT:  if (accept)    state_next = ST_SHIFT;
      ST_HOLD:  if (wait_done) state_next = ST_GAP;
      ST_GAP:   if (wait_done) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == ST_IDLE || state == ST_SHIFT || state == ST_NEXT)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      miso_meta  <= 1'b0;
      miso_sync  <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_q  <= '0;
      bit_cnt    <= '0;
      last_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      miso_meta  <= i_spi_m_miso;
      miso_sync  <= miso_meta;
      rx_valid_q <= done;
      rx_sr      <= rx_next;
      cs_n_q     <= (state_next == ST_IDLE) || (state_next == ST_GAP);
      if (done) rx_data_q <= rx_next;
      if (trail) bit_cnt <= bit_cnt + 1'b1;

      if (accept) begin
        tx_sr  <= i_tx_data;
        last_q <= i_tx_last;
        if (!mode.cpha) mosi_q <= i_tx_data[7];
      end else if (shift) begin
        // CPHA=0 already shows bit 7, so the trailing edge moves on to bit 6.
        mosi_q <= mode.cpha ? tx_sr[7] : tx_sr[6];
        tx_sr  <= {tx_sr[6:0], 1'b0};
      end
    end
  end

  assign o_rx_valid   = rx_valid_q;
  assign o_rx_data    = rx_data_q;
  assign o_busy       = (state != ST_IDLE);
  assign o_spi_m_cs_n = cs_n_q;
  assign o_spi_m_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: loopback and byte-slave MISO sources,
// bursts, stalls and mid-transfer reset; mode 3 when SPI_M_MODE_SEL_EN is set.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int BYTE_CYC = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, rx_valid, busy, sck, cs_n, mosi, miso;
  logic [7:0] rx_data;
`ifdef SPI_M_MODE_SEL_EN
  logic [1:0] mode_in = 2'b00;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
`ifdef SPI_M_MODE_SEL_EN
    .i_mode       (mode_in),
`endif
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .i_tx_data    (tx_data),
    .i_tx_last    (tx_last),
    .o_rx_valid   (rx_valid),
    .o_rx_data    (rx_data),
    .o_busy       (busy),
    .o_spi_m_sck  (sck),
    .o_spi_m_cs_n (cs_n),
    .o_spi_m_mosi (mosi),
    .i_spi_m_miso (miso)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: loads its reply while CSn is high, shifts on SCK falling edges.
  logic       use_slave = 1'b0;
  logic [7:0] slave_bytes [4];
  logic [7:0] sl_sr = 8'h00;
  logic [2:0] sl_bit = 3'd0;
  int         sl_idx = 0;
  logic       sl_prev_sck = 1'b0;

  always @(negedge clk) begin
    if (cs_n) begin
      sl_idx = 0;
      sl_bit = 3'd0;
      sl_sr  = slave_bytes[0];
    end else if (sl_prev_sck && !sck) begin
      if (sl_bit == 3'd7) begin
        sl_idx = (sl_idx + 1) % 4;
        sl_sr  = slave_bytes[sl_idx];
      end else begin
        sl_sr = {sl_sr[6:0], 1'b0};
      end
      sl_bit = sl_bit + 3'd1;
    end
    sl_prev_sck = sck;
  end

  assign miso = use_slave ? sl_sr[7] : mosi;

  // Bus monitors: SCK rise count with MOSI captured at each rise, CSn low length.
  int         rises = 0;
  logic [7:0] mosi_sr = 8'h00;
  int         cs_cur = 0;
  int         cs_last = 0;

  always @(posedge sck) begin
    rises++;
    mosi_sr = {mosi_sr[6:0], mosi};
  end

  always @(negedge clk) begin
    if (!cs_n) cs_cur++;
    else if (cs_cur != 0) begin
      cs_last = cs_cur;
      cs_cur  = 0;
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
      else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic send(input logic [7:0] data, input logic last, input logic [7:0] exp_rx);
    int n;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = data;
    tx_last  = last;
    n = 0;
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(exp_rx);
    end
    #1;
    tx_valid = 1'b0;
    tx_data  = $urandom_range(0, 255);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  int r0;

  initial begin
    slave_bytes[0] = 8'h3C;
    slave_bytes[1] = 8'hC3;
    slave_bytes[2] = 8'h00;
    slave_bytes[3] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n",     {31'd0, cs_n},     32'd1);
    check("rst_sck",      {31'd0, sck},      32'd0);
    check("rst_mosi",     {31'd0, mosi},     32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data",  {24'd0, rx_data},  32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, looped back
    r0 = rises;
    send(8'hAA, 1'b1, 8'hAA);
    repeat (2) @(negedge clk);
    check("single_ready_low", {31'd0, tx_ready}, 32'd0);
    check("single_busy",      {31'd0, busy},     32'd1);
    wait_idle();
    check("single_rises",  rises - r0, 32'd8);
    check("single_mosi",   {24'd0, mosi_sr}, 32'hAA);
    check("single_cs_low", cs_last, BYTE_CYC + CS_SETUP + CS_HOLD);
    check("single_cs_idle", {31'd0, cs_n}, 32'd1);

    // Two-byte burst against the slave model
    use_slave = 1'b1;
    repeat (4) @(negedge clk);
    r0 = rises;
    send(8'hAA, 1'b0, 8'h3C);
    send(8'h55, 1'b1, 8'hC3);
    wait_idle();
    check("burst_rises",  rises - r0, 32'd16);
    check("burst_mosi",   {24'd0, mosi_sr}, 32'h55);
    check("burst_cs_low", cs_last, 2 * BYTE_CYC + 1 + CS_SETUP + CS_HOLD);
    use_slave = 1'b0;
    repeat (4) @(negedge clk);

    // Stall in NEXT between bytes
    send(8'h12, 1'b0, 8'h12);
    for (int i = 0; i < 300 && !(tx_ready && busy); i++) @(negedge clk);
    check("stall_mosi", {24'd0, mosi_sr}, 32'h12);
    r0 = rises;
    repeat (20) @(negedge clk);
    check("stall_rises", rises - r0, 32'd0);
    check("stall_sck",   {31'd0, sck},      32'd0);
    check("stall_cs_n",  {31'd0, cs_n},     32'd0);
    check("stall_ready", {31'd0, tx_ready}, 32'd1);
    send(8'h0F, 1'b1, 8'h0F);
    wait_idle();
    check("stall_mosi2", {24'd0, mosi_sr}, 32'h0F);
    check("stall_rises2", rises - r0, 32'd8);

    // Reset after the third SCK rise
    r0 = rises;
    send(8'h5A, 1'b1, 8'h5A);
    for (int i = 0; i < 300 && (rises - r0) < 3; i++) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n",    {31'd0, cs_n},     32'd1);
    check("abort_sck",     {31'd0, sck},      32'd0);
    check("abort_busy",    {31'd0, busy},     32'd0);
    check("abort_rx_data", {24'd0, rx_data},  32'h00);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    r0 = rises;
    send(8'hF0, 1'b1, 8'hF0);
    wait_idle();
    check("after_abort_rises", rises - r0, 32'd8);
    check("after_abort_mosi",  {24'd0, mosi_sr}, 32'hF0);

`ifdef SPI_M_MODE_SEL_EN
    // Mode 3: SCK idles high, rising edge is the trailing (sampling) edge
    mode_in = 2'b11;
    repeat (3) @(negedge clk);
    check("m3_idle_sck", {31'd0, sck}, 32'd1);
    r0 = rises;
    send(8'hC3, 1'b1, 8'hC3);
    wait_idle();
    check("m3_rises", rises - r0, 32'd8);
    check("m3_mosi",  {24'd0, mosi_sr}, 32'hC3);
    check("m3_sck_after", {31'd0, sck}, 32'd1);
`endif

    repeat (5) @(negedge clk);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
